// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
//
// Shared definitions for the write-back stage and its register file.
//   - XLEN_DEF       : default datapath width
//   - INSTRET_W_DEF  : default retired-instruction counter width
//   - NREGS / REG_AW : register file geometry
//   - rwsel_e        : write-back source encodings used when MemtoReg=0
//   - NOP_BUBBLE     : instruction word that marks a pipeline bubble
//   - trace_pc()     : recovers the instruction PC from its PC+4 value
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int INSTRET_W_DEF = 64;
    localparam int NREGS         = 32;
    localparam int REG_AW        = 5;

    // Write-back source select, consulted only when MemtoReg=0.
    typedef enum logic [1:0] {
        RWSEL_ALU   = 2'b00,
        RWSEL_PC4   = 2'b01,
        RWSEL_IMM   = 2'b10,
        RWSEL_PCIMM = 2'b11
    } rwsel_e;

    // An all-zero instruction word is a bubble and never retires.
    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

    // The trace reports the instruction's own PC; only PC+4 reaches this
    // stage, so step back by 4 (wrapping modulo 2^32 on the default width).
    function automatic logic [XLEN_DEF-1:0] trace_pc(input logic [XLEN_DEF-1:0] pc_four);
        return pc_four - XLEN_DEF'(4);
    endfunction

endpackage

// File: rtl/wb_stage_reg_file.sv
// ---------------------------------------------------------------------------
// wb_stage_reg_file
//
// 32 x XLEN integer register file.
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high clear of every entry
//   we     in   write enable (caller guarantees no write to x0 is needed;
//               x0 is guarded here as well)
//   waddr  in   write address
//   wdata  in   write data
//   raddr1 in   read address, port 1
//   raddr2 in   read address, port 2
//   rdata1 out  read data, port 1 (combinational, x0 reads 0)
//   rdata2 out  read data, port 2 (combinational, x0 reads 0)
//
// Reads return stored state only; same-cycle bypass of the write port is
// done by the enclosing stage.
// ---------------------------------------------------------------------------
module wb_stage_reg_file
    import wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is cleared by reset and never written, so it stays zero; the
    // read muxes still force 0 so x0 does not depend on that storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = regs[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//
// Write-back stage fed by the MEM/WB pipeline register.
//   clk, reset                     clock and synchronous active-high reset
//   RegWrite, MemtoReg, RWSel      write-back controls
//   Pc_Imm, Pc_Four, Imm_Out,
//   Alu_Result, MemReadData        candidate write-back values
//   rd                             destination register
//   Curr_Instr                     instruction word, 0 = bubble
//   rs1, rs2                       decode-stage read addresses
//   rs1_data, rs2_data  out        read data with same-cycle write bypass
//   WB_Data             out        selected write-back value (forwarding)
//   WB_Rd               out        rd, 0 when no effective write
//   WB_En               out        RegWrite && rd != 0
//   Instret             out        retired-instruction counter (wraps)
//   Retire_Valid        out        one-cycle pulse: trace entry is new
//   Retire_Pc/Data/Instr/Rd out    registered trace of the last retirement
//
// Retirement is any non-bubble instruction, independent of RegWrite, so
// stores and branches are counted and traced with Retire_Rd/Retire_Data=0.
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int INSTRET_W = INSTRET_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic                 MemtoReg,
    input  logic [1:0]           RWSel,
    input  logic [XLEN-1:0]      Pc_Imm,
    input  logic [XLEN-1:0]      Pc_Four,
    input  logic [XLEN-1:0]      Imm_Out,
    input  logic [XLEN-1:0]      Alu_Result,
    input  logic [XLEN-1:0]      MemReadData,
    input  logic [REG_AW-1:0]    rd,
    input  logic [31:0]          Curr_Instr,
    input  logic [REG_AW-1:0]    rs1,
    input  logic [REG_AW-1:0]    rs2,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic [XLEN-1:0]      WB_Data,
    output logic [REG_AW-1:0]    WB_Rd,
    output logic                 WB_En,
    output logic [INSTRET_W-1:0] Instret,
    output logic                 Retire_Valid,
    output logic [XLEN-1:0]      Retire_Pc,
    output logic [XLEN-1:0]      Retire_Data,
    output logic [31:0]          Retire_Instr,
    output logic [REG_AW-1:0]    Retire_Rd
);

    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic            retire;

    // -----------------------------------------------------------------------
    // Write-back source select: a load result always wins over RWSel.
    // -----------------------------------------------------------------------
    always_comb begin
        WB_Data = Alu_Result;
        if (MemtoReg) begin
            WB_Data = MemReadData;
        end else begin
            case (rwsel_e'(RWSel))
                RWSEL_ALU:   WB_Data = Alu_Result;
                RWSEL_PC4:   WB_Data = Pc_Four;
                RWSEL_IMM:   WB_Data = Imm_Out;
                RWSEL_PCIMM: WB_Data = Pc_Imm;
                default:     WB_Data = Alu_Result;
            endcase
        end
    end

    // A write to x0 is treated as no write at all, so forwarding logic
    // downstream never matches on register 0.
    assign WB_En  = RegWrite && (rd != '0);
    assign WB_Rd  = WB_En ? rd : '0;
    assign retire = (Curr_Instr != NOP_BUBBLE);

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    wb_stage_reg_file #(
        .XLEN (XLEN)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (WB_En),
        .waddr  (rd),
        .wdata  (WB_Data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // -----------------------------------------------------------------------
    // Read ports with same-cycle bypass. The write lands in storage only at
    // the next edge, so a reader of rd this cycle must see WB_Data directly.
    // WB_En already excludes rd=0, so an x0 read never bypasses.
    // -----------------------------------------------------------------------
    always_comb begin
        rs1_data = rf_rdata1;
        rs2_data = rf_rdata2;
        if (rs1 == '0) begin
            rs1_data = '0;
        end else if (WB_En && (rs1 == rd)) begin
            rs1_data = WB_Data;
        end
        if (rs2 == '0) begin
            rs2_data = '0;
        end else if (WB_En && (rs2 == rd)) begin
            rs2_data = WB_Data;
        end
    end

    // -----------------------------------------------------------------------
    // Retired-instruction counter and one-entry retire trace. Reset dominates
    // so a retirement presented in the reset cycle is dropped. Trace fields
    // other than Retire_Valid hold across bubbles.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            Instret      <= '0;
            Retire_Valid <= 1'b0;
            Retire_Pc    <= '0;
            Retire_Data  <= '0;
            Retire_Instr <= '0;
            Retire_Rd    <= '0;
        end else begin
            Retire_Valid <= retire;
            if (retire) begin
                Instret      <= Instret + INSTRET_W'(1);
                Retire_Instr <= Curr_Instr;
                Retire_Pc    <= Pc_Four - XLEN'(4);
                Retire_Data  <= WB_En ? WB_Data : '0;
                Retire_Rd    <= WB_Rd;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage: directed check of the write-back stage. A second instance
// with a 3-bit counter shares every input so the counter wrap from
// all-ones to zero can be reached in a handful of retirements.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic        MemtoReg;
    logic [1:0]  RWSel;
    logic [31:0] Pc_Imm;
    logic [31:0] Pc_Four;
    logic [31:0] Imm_Out;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
    logic [4:0]  rd;
    logic [31:0] Curr_Instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic [31:0] rs1_data, rs2_data, WB_Data;
    logic [4:0]  WB_Rd;
    logic        WB_En;
    logic [63:0] Instret;
    logic        Retire_Valid;
    logic [31:0] Retire_Pc, Retire_Data, Retire_Instr;
    logic [4:0]  Retire_Rd;

    logic [31:0] w_rs1_data, w_rs2_data, w_WB_Data;
    logic [4:0]  w_WB_Rd;
    logic        w_WB_En;
    logic [2:0]  w_Instret;
    logic        w_Retire_Valid;
    logic [31:0] w_Retire_Pc, w_Retire_Data, w_Retire_Instr;
    logic [4:0]  w_Retire_Rd;

    int compared   = 0;
    int mismatched = 0;

    wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .RWSel(RWSel), .Pc_Imm(Pc_Imm), .Pc_Four(Pc_Four), .Imm_Out(Imm_Out),
        .Alu_Result(Alu_Result), .MemReadData(MemReadData), .rd(rd),
        .Curr_Instr(Curr_Instr), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .WB_Data(WB_Data),
        .WB_Rd(WB_Rd), .WB_En(WB_En), .Instret(Instret),
        .Retire_Valid(Retire_Valid), .Retire_Pc(Retire_Pc),
        .Retire_Data(Retire_Data), .Retire_Instr(Retire_Instr),
        .Retire_Rd(Retire_Rd)
    );

    wb_stage #(.XLEN(32), .INSTRET_W(3)) dut_w (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .RWSel(RWSel), .Pc_Imm(Pc_Imm), .Pc_Four(Pc_Four), .Imm_Out(Imm_Out),
        .Alu_Result(Alu_Result), .MemReadData(MemReadData), .rd(rd),
        .Curr_Instr(Curr_Instr), .rs1(rs1), .rs2(rs2),
        .rs1_data(w_rs1_data), .rs2_data(w_rs2_data), .WB_Data(w_WB_Data),
        .WB_Rd(w_WB_Rd), .WB_En(w_WB_En), .Instret(w_Instret),
        .Retire_Valid(w_Retire_Valid), .Retire_Pc(w_Retire_Pc),
        .Retire_Data(w_Retire_Data), .Retire_Instr(w_Retire_Instr),
        .Retire_Rd(w_Retire_Rd)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled a
    // further unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RWSel       = 2'b00;
        Pc_Imm      = '0;
        Pc_Four     = '0;
        Imm_Out     = '0;
        Alu_Result  = '0;
        MemReadData = '0;
        rd          = '0;
        Curr_Instr  = '0;
        rs1         = '0;
        rs2         = '0;
    endtask

    task automatic write_op(input logic mtr, input logic [1:0] sel,
                            input logic [4:0] dst, input logic [31:0] instr,
                            input logic [31:0] pc4);
        RegWrite   = 1'b1;
        MemtoReg   = mtr;
        RWSel      = sel;
        rd         = dst;
        Curr_Instr = instr;
        Pc_Four    = pc4;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;

        // ---- reset ----
        tick();
        reset = 1'b0;
        rs1 = 5'd5;
        settle();
        check("rst_instret", Instret, 64'd0);
        check("rst_retire_valid", 64'(Retire_Valid), 64'd0);
        check("rst_x5", 64'(rs1_data), 64'd0);

        // ---- JAL-style write of PC+4 to x3, same-cycle bypass ----
        write_op(1'b0, 2'b01, 5'd3, 32'h0040_00EF, 32'h0000_0104);
        Alu_Result = 32'h0000_0999;
        rs1 = 5'd3;
        rs2 = 5'd3;
        settle();
        check("pc4_wb_data", 64'(WB_Data), 64'h104);
        check("pc4_bypass_rs1", 64'(rs1_data), 64'h104);
        check("pc4_bypass_rs2", 64'(rs2_data), 64'h104);
        check("pc4_wb_en", 64'(WB_En), 64'd1);
        check("pc4_wb_rd", 64'(WB_Rd), 64'd3);
        tick();
        idle();
        rs1 = 5'd3;
        settle();
        check("pc4_ret_valid", 64'(Retire_Valid), 64'd1);
        check("pc4_ret_pc", 64'(Retire_Pc), 64'h100);
        check("pc4_ret_rd", 64'(Retire_Rd), 64'd3);
        check("pc4_ret_data", 64'(Retire_Data), 64'h104);
        check("pc4_ret_instr", 64'(Retire_Instr), 64'h0040_00EF);
        check("pc4_instret", Instret, 64'd1);
        check("pc4_x3_stored", 64'(rs1_data), 64'h104);

        // ---- load to x7: MemtoReg overrides RWSel=IMM ----
        write_op(1'b1, 2'b10, 5'd7, 32'h0002_A383, 32'h0000_0108);
        MemReadData = 32'hDEAD_BEEF;
        Imm_Out     = 32'h0000_1234;
        settle();
        check("ld_wb_data", 64'(WB_Data), 64'hDEAD_BEEF);
        tick();
        idle();
        rs2 = 5'd7;
        settle();
        check("ld_x7_stored", 64'(rs2_data), 64'hDEAD_BEEF);
        check("ld_instret", Instret, 64'd2);
        check("ld_ret_pc", 64'(Retire_Pc), 64'h104);

        // ---- remaining RWSel sources into x10, x11, x12 ----
        write_op(1'b0, 2'b00, 5'd10, 32'h0020_8533, 32'h0000_010C);
        Alu_Result = 32'h1111_1111;
        Imm_Out    = 32'h2222_2222;
        Pc_Imm     = 32'h3333_3333;
        settle();
        check("alu_wb_data", 64'(WB_Data), 64'h1111_1111);
        tick();
        write_op(1'b0, 2'b10, 5'd11, 32'h1234_55B7, 32'h0000_0110);
        settle();
        check("imm_wb_data", 64'(WB_Data), 64'h2222_2222);
        tick();
        write_op(1'b0, 2'b11, 5'd12, 32'h0000_1617, 32'h0000_0114);
        rs1 = 5'd10;
        rs2 = 5'd11;
        settle();
        check("pcimm_wb_data", 64'(WB_Data), 64'h3333_3333);
        check("alu_x10_stored", 64'(rs1_data), 64'h1111_1111);
        check("imm_x11_stored", 64'(rs2_data), 64'h2222_2222);
        tick();
        idle();
        rs1 = 5'd12;
        settle();
        check("pcimm_x12_stored", 64'(rs1_data), 64'h3333_3333);
        check("sel_instret", Instret, 64'd5);

        // ---- write to x0 is suppressed but still retires ----
        write_op(1'b0, 2'b00, 5'd0, 32'h0550_0013, 32'h0000_0200);
        Alu_Result = 32'h0000_0055;
        rs1 = 5'd0;
        settle();
        check("x0_wb_en", 64'(WB_En), 64'd0);
        check("x0_wb_rd", 64'(WB_Rd), 64'd0);
        check("x0_read_bypass", 64'(rs1_data), 64'd0);
        tick();
        idle();
        settle();
        check("x0_read_stored", 64'(rs1_data), 64'd0);
        check("x0_ret_valid", 64'(Retire_Valid), 64'd1);
        check("x0_ret_rd", 64'(Retire_Rd), 64'd0);
        check("x0_ret_data", 64'(Retire_Data), 64'd0);
        check("x0_ret_pc", 64'(Retire_Pc), 64'h1FC);
        check("x0_instret", Instret, 64'd6);

        // ---- three bubbles: counter and trace fields hold ----
        tick();
        tick();
        tick();
        check("bub_instret", Instret, 64'd6);
        check("bub_ret_valid", 64'(Retire_Valid), 64'd0);
        check("bub_ret_pc_hold", 64'(Retire_Pc), 64'h1FC);
        check("bub_ret_instr_hold", 64'(Retire_Instr), 64'h0550_0013);

        // ---- back-to-back writes to x3: bypass tracks current write ----
        write_op(1'b0, 2'b00, 5'd3, 32'h0000_0193, 32'h0000_0300);
        Alu_Result = 32'h0000_AAAA;
        rs1 = 5'd3;
        settle();
        check("b2b_bypass1", 64'(rs1_data), 64'hAAAA);
        tick();
        Alu_Result = 32'h0000_BBBB;
        Pc_Four    = 32'h0000_0304;
        settle();
        check("b2b_bypass2", 64'(rs1_data), 64'hBBBB);
        tick();
        idle();
        rs1 = 5'd3;
        settle();
        check("b2b_last_wins", 64'(rs1_data), 64'hBBBB);
        check("b2b_instret", Instret, 64'd8);

        // ---- write and retire presented under reset are dropped ----
        reset = 1'b1;
        write_op(1'b0, 2'b00, 5'd9, 32'h0990_0493, 32'h0000_0400);
        Alu_Result = 32'h0000_0099;
        tick();
        reset = 1'b0;
        idle();
        rs1 = 5'd9;
        rs2 = 5'd3;
        settle();
        check("rstw_x9", 64'(rs1_data), 64'd0);
        check("rstw_x3_cleared", 64'(rs2_data), 64'd0);
        check("rstw_instret", Instret, 64'd0);
        check("rstw_ret_valid", 64'(Retire_Valid), 64'd0);
        check("rstw_ret_pc", 64'(Retire_Pc), 64'd0);
        check("rstw_ret_instr", 64'(Retire_Instr), 64'd0);

        // ---- counter wrap on the 3-bit instance: 7 retires reach all-ones,
        //      the 8th wraps to 0 while the 64-bit counter reads 8 ----
        for (int i = 0; i < 7; i++) begin
            Curr_Instr = 32'h0000_0013;
            Pc_Four    = 32'h0000_0500 + 32'(4 * i);
            tick();
        end
        Curr_Instr = '0;
        settle();
        check("wrap_allones", 64'(w_Instret), 64'h7);
        Curr_Instr = 32'h0000_0013;
        tick();
        Curr_Instr = '0;
        settle();
        check("wrap_zero", 64'(w_Instret), 64'd0);
        check("wrap_ret_valid", 64'(w_Retire_Valid), 64'd1);
        check("wrap_wide_instret", Instret, 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Bound on total run time in case a step never completes.
    initial begin
        #20000;
        $display("FAIL timeout compared=%0d", compared);
        $fatal(1, "timeout");
    end

endmodule
